alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator-side companion to the team's 8-bit combinational ALU.
- Accepts tagged operation commands over a valid/ready stream and buffers them in a small FIFO.
- Drives one command at a time onto the ALU operand/opcode ports, waits a programmable settle time, then captures result/zero/carry.
- Returns each capture, with its tag, over a valid/ready response stream. Sits between a testbench or CPU-side requester and the ALU instance.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
SETTLE_CYC, 1, cycles ALU ports are held before capture (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (= !full; 0 while rst high)
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_op  input  3  ALU opcode
cmd_tag  input  4  requester tag, returned unchanged
alu_a  output  8  to ALU a
alu_b  output  8  to ALU b
alu_op  output  3  to ALU op
alu_result  input  8  from ALU result
alu_zero  input  1  from ALU zero
alu_carry  input  1  from ALU carry
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  8  captured result
rsp_zero  output  1  captured zero
rsp_carry  output  1  captured carry
rsp_tag  output  4  tag of this response
busy  output  1  state != IDLE or FIFO non-empty
op_count  output  16  completed response handshakes, wraps 0xFFFF->0x0000
chk_err  output  1  sticky self-check error (Optional Feature)
chk_err_cnt  output  8  self-check mismatch count, saturates at 0xFF

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, settle counter 0. Reset is async: it aborts any in-flight command, discards FIFO contents and emits no response.
- FIFO push: on the edge where cmd_valid && cmd_ready.
- FIFO pop: in IDLE when non-empty.
- Simultaneous push and pop are legal; occupancy is unchanged.
- cmd_ready depends only on registered occupancy, with no combinational path from rsp_ready.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop the head; register alu_a/alu_b/alu_op and the tag; cnt <= SETTLE_CYC-1; go to EXEC.
  - EXEC: alu_* held constant. If cnt==0, register alu_result/zero/carry into rsp_*, set rsp_valid, go to RESP. Otherwise decrement cnt.
  - RESP: rsp_* held stable while rsp_valid && !rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid, increment op_count, go to IDLE.
- Latency: when idle with an empty FIFO, rsp_valid rises SETTLE_CYC+1 edges after the accept edge. There is a one-cycle IDLE bubble between back-to-back commands.
- Ordering: responses return strictly in command order.
- Capacity: DEPTH queued commands plus 1 in flight, so DEPTH+1 commands are accepted while rsp_ready is held low.
- alu_* keep their last values in IDLE/RESP and are not cleared between commands.

Optional Feature:
Macro ALU_SEQ_CHECK_EN.
- Defined: an internal reference model computes expected {carry,result,zero} from the registered operands at capture time:
  - ADD: 9-bit sum.
  - SUB: 9-bit difference, carry=1 when a<b.
  - AND/OR/XOR/NOT: carry 0.
  - SLL: {a[6:0],0}, carry=a[7].
  - SRL: {0,a[7:1]}, carry 0.
  - zero = (result==0).
  - On any field mismatch at the capture edge: chk_err <= 1 (sticky until reset) and chk_err_cnt increments (saturating).
- Undefined: no model logic is present; chk_err and chk_err_cnt are tied to 0.

Test Plan:
- ADD a=0xF0 b=0x20 tag=3, rsp_ready=1, SETTLE_CYC=1 -> rsp_valid 2 edges after accept; result=0x10, carry=1, zero=0, tag=3; op_count=1.
- SUB 0x05-0x05 -> result=0x00, zero=1, carry=0. Then SUB 0x03-0x05 -> result=0xFE, carry=1, zero=0.
- rsp_ready=0, push tags 0..5 (DEPTH=4) -> 5 accepted and cmd_ready=0 on the 6th; rsp_* stable on tag 0. Then release rsp_ready -> tags 0..5 returned in order; op_count=6.
- SLL a=0x81 -> result=0x02, carry=1. SRL a=0x01 -> result=0x00, zero=1, carry=0.
- SETTLE_CYC=3: assert rst during EXEC -> all outputs 0 immediately, FIFO empty; after deassert no response appears and cmd_ready=1.
- ALU_SEQ_CHECK_EN defined, ALU model with result bit0 forced to 1, AND 0x00&0x00 -> chk_err=1, chk_err_cnt=1. Same stimulus without the macro -> both remain 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers tagged ALU commands in a FIFO, drives them onto the
// ALU one at a time, captures result/zero/carry after SETTLE_CYC cycles and
// returns each capture with its tag over a valid/ready response stream.
// Optional build macro ALU_SEQ_CHECK_EN adds a reference model that flags ALU
// captures disagreeing with the expected result (chk_err / chk_err_cnt).
module alu_cmd_sequencer #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   input  logic [3:0]  cmd_tag,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   input  logic [7:0]  alu_result,
   input  logic        alu_zero,
   input  logic        alu_carry,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_result,
   output logic        rsp_zero,
   output logic        rsp_carry,
   output logic [3:0]  rsp_tag,
   output logic        busy,
   output logic [15:0] op_count,
   output logic        chk_err,
   output logic [7:0]  chk_err_cnt
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   typedef struct packed {
      logic [3:0] tag;
      logic [2:0] op;
      logic [7:0] b;
      logic [7:0] a;
   } cmd_t;

   cmd_t             r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [1:0]       r_state;
   logic [SW-1:0]    r_cnt;
   logic             r_cmd_ready;
   logic             r_busy;
   logic [7:0]       r_alu_a;
   logic [7:0]       r_alu_b;
   logic [2:0]       r_alu_op;
   logic [3:0]       r_tag;
   logic             r_rsp_valid;
   logic [7:0]       r_rsp_result;
   logic             r_rsp_zero;
   logic             r_rsp_carry;
   logic [3:0]       r_rsp_tag;
   logic [15:0]      r_op_count;

   logic [1:0]       w_state_nxt;
   logic             w_push;
   logic             w_pop;
   logic             w_capture;
   logic             w_rsp_done;
   logic [CW-1:0]    w_count_nxt;
   cmd_t             w_head;

   assign w_push      = cmd_valid && r_cmd_ready;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   // Next-state and per-cycle strobes for the command/response sequencing
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      w_rsp_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (r_rsp_valid && rsp_ready) begin
               w_rsp_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{tag: cmd_tag, op: cmd_op, b: cmd_b, a: cmd_a};
      end
   end

   // FIFO pointers, occupancy, and flags derived from next occupancy/state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count     <= w_count_nxt;
         r_cmd_ready <= (w_count_nxt != CW'(DEPTH));
         r_busy      <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      end
   end

   // ALU operand drive and settle countdown; operands persist between commands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
         r_tag    <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_pop) begin
            r_alu_a  <= w_head.a;
            r_alu_b  <= w_head.b;
            r_alu_op <= w_head.op;
            r_tag    <= w_head.tag;
            r_cnt    <= SW'(SETTLE_CYC - 1);
         end else if ((r_state == S_EXEC) && !w_capture) begin
            r_cnt <= r_cnt - SW'(1);
         end
      end
   end

   // Response capture, hold-until-accepted, and completion counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_zero   <= 1'b0;
         r_rsp_carry  <= 1'b0;
         r_rsp_tag    <= '0;
         r_op_count   <= '0;
      end else begin
         if (w_capture) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
            r_rsp_carry  <= alu_carry;
            r_rsp_tag    <= r_tag;
         end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
         end
         if (w_rsp_done) begin
            r_op_count <= r_op_count + 16'd1;
         end
      end
   end

`ifdef ALU_SEQ_CHECK_EN
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NOT = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;

   logic [8:0] w_ref_wide;
   logic [7:0] w_ref_result;
   logic       w_ref_carry;
   logic       w_ref_zero;
   logic       w_chk_mismatch;
   logic       r_chk_err;
   logic [7:0] r_chk_err_cnt;

   // Reference {carry,result} from the operands currently held on the ALU ports
   always_comb begin
      w_ref_wide = '0;
      case (r_alu_op)
         OP_ADD:  w_ref_wide = {1'b0, r_alu_a} + {1'b0, r_alu_b};
         OP_SUB:  w_ref_wide = {1'b0, r_alu_a} - {1'b0, r_alu_b};
         OP_AND:  w_ref_wide = {1'b0, r_alu_a & r_alu_b};
         OP_OR:   w_ref_wide = {1'b0, r_alu_a | r_alu_b};
         OP_XOR:  w_ref_wide = {1'b0, r_alu_a ^ r_alu_b};
         OP_NOT:  w_ref_wide = {1'b0, ~r_alu_a};
         OP_SLL:  w_ref_wide = {r_alu_a, 1'b0};
         OP_SRL:  w_ref_wide = {2'b00, r_alu_a[7:1]};
         default: w_ref_wide = '0;
      endcase
   end

   assign w_ref_result   = w_ref_wide[7:0];
   assign w_ref_carry    = w_ref_wide[8];
   assign w_ref_zero     = (w_ref_result == 8'h00);
   assign w_chk_mismatch = w_capture &&
      ({alu_carry, alu_result, alu_zero} != {w_ref_carry, w_ref_result, w_ref_zero});

   // Sticky error flag and saturating mismatch counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chk_err     <= 1'b0;
         r_chk_err_cnt <= '0;
      end else if (w_chk_mismatch) begin
         r_chk_err <= 1'b1;
         if (r_chk_err_cnt != 8'hFF) begin
            r_chk_err_cnt <= r_chk_err_cnt + 8'd1;
         end
      end
   end

   assign chk_err     = r_chk_err;
   assign chk_err_cnt = r_chk_err_cnt;
`else
   assign chk_err     = 1'b0;
   assign chk_err_cnt = 8'h00;
`endif

   assign cmd_ready  = r_cmd_ready;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_zero   = r_rsp_zero;
   assign rsp_carry  = r_rsp_carry;
   assign rsp_tag    = r_rsp_tag;
   assign busy       = r_busy;
   assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a queue-based model of expected responses is
// checked every cycle on the main instance (SETTLE_CYC=1); a second instance
// (SETTLE_CYC=3) covers longer settle latency and reset during execution.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NOT = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;
`ifdef ALU_SEQ_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, rst_3;
   always #5 clk = ~clk;

   // main instance signals
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_a, cmd_b;
   logic [2:0]  cmd_op;
   logic [3:0]  cmd_tag;
   logic [7:0]  alu_a, alu_b, alu_result;
   logic [2:0]  alu_op;
   logic        alu_zero, alu_carry;
   logic        rsp_valid, rsp_ready, rsp_zero, rsp_carry;
   logic [7:0]  rsp_result;
   logic [3:0]  rsp_tag;
   logic        busy, chk_err;
   logic [15:0] op_count;
   logic [7:0]  chk_err_cnt;

   // second instance signals
   logic        cmd_valid_3, cmd_ready_3;
   logic [7:0]  cmd_a_3, cmd_b_3;
   logic [2:0]  cmd_op_3;
   logic [3:0]  cmd_tag_3;
   logic [7:0]  alu_a_3, alu_b_3, alu_result_3;
   logic [2:0]  alu_op_3;
   logic        alu_zero_3, alu_carry_3;
   logic        rsp_valid_3, rsp_ready_3, rsp_zero_3, rsp_carry_3;
   logic [7:0]  rsp_result_3;
   logic [3:0]  rsp_tag_3;
   logic        busy_3, chk_err_3;
   logic [15:0] op_count_3;
   logic [7:0]  chk_err_cnt_3;

   bit g_force = 1'b0;
   int n_tests = 0;
   int n_fail  = 0;

   // ALU behaviour returned as {carry, result[7:0], zero}; force1 models a stuck result bit0
   function automatic logic [9:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input bit force1);
      logic [8:0] r;
      case (op)
         OP_ADD:  r = {1'b0, a} + {1'b0, b};
         OP_SUB:  r = {1'b0, a} - {1'b0, b};
         OP_AND:  r = {1'b0, a & b};
         OP_OR:   r = {1'b0, a | b};
         OP_XOR:  r = {1'b0, a ^ b};
         OP_NOT:  r = {1'b0, ~a};
         OP_SLL:  r = {a[7], a[6:0], 1'b0};
         default: r = {2'b00, a[7:1]};
      endcase
      if (force1) r[0] = 1'b1;
      return {r[8], r[7:0], (r[7:0] == 8'h00)};
   endfunction

   assign {alu_carry, alu_result, alu_zero}       = alu_fn(alu_op, alu_a, alu_b, g_force);
   assign {alu_carry_3, alu_result_3, alu_zero_3} = alu_fn(alu_op_3, alu_a_3, alu_b_3, 1'b0);

   alu_cmd_sequencer #(.DEPTH(4), .SETTLE_CYC(1)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .alu_zero(alu_zero), .alu_carry(alu_carry), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .busy(busy), .op_count(op_count),
      .chk_err(chk_err), .chk_err_cnt(chk_err_cnt));

   alu_cmd_sequencer #(.DEPTH(4), .SETTLE_CYC(3)) u_dut_s3 (
      .clk(clk), .rst(rst_3), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
      .cmd_a(cmd_a_3), .cmd_b(cmd_b_3), .cmd_op(cmd_op_3), .cmd_tag(cmd_tag_3),
      .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_op(alu_op_3), .alu_result(alu_result_3),
      .alu_zero(alu_zero_3), .alu_carry(alu_carry_3), .rsp_valid(rsp_valid_3),
      .rsp_ready(rsp_ready_3), .rsp_result(rsp_result_3), .rsp_zero(rsp_zero_3),
      .rsp_carry(rsp_carry_3), .rsp_tag(rsp_tag_3), .busy(busy_3), .op_count(op_count_3),
      .chk_err(chk_err_3), .chk_err_cnt(chk_err_cnt_3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: expected responses in command order ----------------
   typedef struct {
      logic [7:0] a, b;
      logic [2:0] op;
      logic [3:0] tag;
      logic [9:0] res;
      bit         bad;
   } exp_t;

   exp_t exp_q[$];
   int   outstanding = 0;
   int   n_hs        = 0;
   int   n_acc       = 0;
   int   exp_err_cnt = 0;
   int   counted_for = -1;

   // Track accepted commands and completed handshakes as seen at each edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         outstanding = 0;
         n_hs        = 0;
         n_acc       = 0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            exp_t e;
            e.a   = cmd_a;
            e.b   = cmd_b;
            e.op  = cmd_op;
            e.tag = cmd_tag;
            e.res = alu_fn(cmd_op, cmd_a, cmd_b, g_force);
            e.bad = (e.res != alu_fn(cmd_op, cmd_a, cmd_b, 1'b0));
            exp_q.push_back(e);
            outstanding++;
            n_acc++;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            outstanding--;
            n_hs++;
         end
      end
   end

   // Compare main instance against the model every cycle
   always @(negedge clk) begin
      if (rst) begin
         exp_err_cnt = 0;
         counted_for = -1;
      end else begin
         check("busy", busy, outstanding != 0);
         check("op_count", op_count, n_hs[15:0]);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
               check("rsp_result", rsp_result, exp_q[0].res[8:1]);
               check("rsp_carry", rsp_carry, exp_q[0].res[9]);
               check("rsp_zero", rsp_zero, exp_q[0].res[0]);
               check("rsp_tag", rsp_tag, exp_q[0].tag);
               check("alu_a_hold", alu_a, exp_q[0].a);
               check("alu_b_hold", alu_b, exp_q[0].b);
               check("alu_op_hold", alu_op, exp_q[0].op);
               if (counted_for != n_hs) begin
                  counted_for = n_hs;
                  if (exp_q[0].bad && exp_err_cnt < 255) exp_err_cnt++;
               end
            end
         end
         check("chk_err", chk_err, CHK_EN && (exp_err_cnt != 0));
         check("chk_err_cnt", chk_err_cnt, CHK_EN ? exp_err_cnt : 0);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag);
      int guard = 0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
      while (!cmd_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) check("send_timeout", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send3(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag);
      int guard = 0;
      cmd_op_3 = op; cmd_a_3 = a; cmd_b_3 = b; cmd_tag_3 = tag; cmd_valid_3 = 1'b1;
      while (!cmd_ready_3 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready_3) check("send3_timeout", cmd_ready_3, 1'b1);
      @(negedge clk);
      cmd_valid_3 = 1'b0;
   endtask

   // Edges counted from the accept edge until rsp_valid is seen
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) check("rsp_timeout", rsp_valid, 1'b1);
   endtask

   task automatic expect_rsp(input string name, input logic [7:0] res, input logic c,
                             input logic z);
      int lat;
      wait_rsp(lat);
      check({name, "_result"}, rsp_result, res);
      check({name, "_carry"}, rsp_carry, c);
      check({name, "_zero"}, rsp_zero, z);
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int guard;
      rst = 1'b1; rst_3 = 1'b1;
      cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0; rsp_ready = 1'b0;
      cmd_valid_3 = 1'b0; cmd_a_3 = '0; cmd_b_3 = '0; cmd_op_3 = '0; cmd_tag_3 = '0;
      rsp_ready_3 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_op_count", op_count, 16'h0);
      check("rst_alu_a", alu_a, 8'h00);
      check("rst_rsp_tag", rsp_tag, 4'h0);
      rst = 1'b0; rst_3 = 1'b0;
      @(negedge clk);
      check("ready_after_rst", cmd_ready, 1'b1);

      // ADD with carry out, latency from idle
      rsp_ready = 1'b1;
      send(OP_ADD, 8'hF0, 8'h20, 4'd3);
      wait_rsp(lat);
      check("add_latency", lat, 2);
      check("add_result", rsp_result, 8'h10);
      check("add_carry", rsp_carry, 1'b1);
      check("add_zero", rsp_zero, 1'b0);
      check("add_tag", rsp_tag, 4'd3);
      @(negedge clk);
      check("add_op_count", op_count, 16'd1);
      check("add_rsp_cleared", rsp_valid, 1'b0);

      // SUB to zero, then SUB with borrow
      send(OP_SUB, 8'h05, 8'h05, 4'd1);
      expect_rsp("sub_eq", 8'h00, 1'b0, 1'b1);
      send(OP_SUB, 8'h03, 8'h05, 4'd2);
      expect_rsp("sub_borrow", 8'hFE, 1'b1, 1'b0);

      // Fill: DEPTH queued plus one in flight while the consumer stalls
      rsp_ready = 1'b0;
      for (int t = 0; t < 5; t++) send(OP_XOR, 8'(t * 17), 8'h5A, 4'(t));
      cmd_op = OP_OR; cmd_a = 8'h11; cmd_b = 8'h22; cmd_tag = 4'd5; cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_cmd_ready", cmd_ready, 1'b0);
         check("full_rsp_valid", rsp_valid, 1'b1);
         check("full_rsp_tag", rsp_tag, 4'd0);
      end
      check("full_accepted", n_acc, 8);
      rsp_ready = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      guard = 0;
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("drain_idle", busy, 1'b0);
      check("drain_op_count", op_count, 16'd9);

      // Shifts, NOT and 8-bit wrap to zero
      send(OP_SLL, 8'h81, 8'h00, 4'd4);
      expect_rsp("sll", 8'h02, 1'b1, 1'b0);
      send(OP_SRL, 8'h01, 8'h00, 4'd5);
      expect_rsp("srl", 8'h00, 1'b0, 1'b1);
      send(OP_NOT, 8'hFF, 8'h00, 4'd6);
      expect_rsp("not", 8'h00, 1'b0, 1'b1);
      send(OP_ADD, 8'hFF, 8'h01, 4'd7);
      expect_rsp("add_wrap", 8'h00, 1'b1, 1'b1);

      // Faulty ALU (result bit0 stuck high) on AND 0&0
      g_force = 1'b1;
      send(OP_AND, 8'h00, 8'h00, 4'd9);
      wait_rsp(lat);
      check("fault_result", rsp_result, 8'h01);
      check("fault_chk_err", chk_err, CHK_EN);
      check("fault_chk_cnt", chk_err_cnt, CHK_EN ? 8'd1 : 8'd0);
      @(negedge clk);
      g_force = 1'b0;
      @(negedge clk);

      // SETTLE_CYC=3 instance: latency, then reset while executing
      rsp_ready_3 = 1'b1;
      send3(OP_ADD, 8'h01, 8'h02, 4'd7);
      lat = 0;
      while (!rsp_valid_3 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("s3_latency", lat, 4);
      check("s3_result", rsp_result_3, 8'h03);
      check("s3_tag", rsp_tag_3, 4'd7);
      @(negedge clk);
      check("s3_op_count", op_count_3, 16'd1);
      send3(OP_SUB, 8'h09, 8'h04, 4'd8);
      @(negedge clk);
      check("s3_busy_exec", busy_3, 1'b1);
      check("s3_alu_a_exec", alu_a_3, 8'h09);
      #1 rst_3 = 1'b1;
      #1;
      check("s3_rst_rsp_valid", rsp_valid_3, 1'b0);
      check("s3_rst_cmd_ready", cmd_ready_3, 1'b0);
      check("s3_rst_busy", busy_3, 1'b0);
      check("s3_rst_op_count", op_count_3, 16'd0);
      check("s3_rst_alu_a", alu_a_3, 8'h00);
      check("s3_rst_alu_op", alu_op_3, 3'd0);
      @(negedge clk);
      rst_3 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("s3_no_rsp_after_rst", rsp_valid_3, 1'b0);
      end
      check("s3_ready_after_rst", cmd_ready_3, 1'b1);
      check("s3_idle_after_rst", busy_3, 1'b0);

      check("model_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
